// File: rtl/div3_serial_checker_pkg.sv
// Remainder-mod-3 state type and transition function for the serial div-by-3 checker.
package div3_pkg;

   typedef enum logic [1:0] {
      REM0 = 2'b00,
      REM1 = 2'b01,
      REM2 = 2'b10
   } rem_e;

   // n = (2*r + x) mod 3; the unused 2'b11 encoding recovers to REM0.
   // Ternaries on x keep an X on the input visible in the result.
   function automatic rem_e next_rem(rem_e r, logic x);
      rem_e n;
      case (r)
         REM0:    n = x ? REM1 : REM0;
         REM1:    n = x ? REM0 : REM2;
         REM2:    n = x ? REM2 : REM1;
         default: n = REM0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/div3_serial_checker_if.sv
// Serial bit in / divisibility flag out for div3_serial_checker.
interface div3_serial_checker_if;
   logic x_i;
   logic div_o;

   modport master (output x_i, input div_o);
   modport slave  (input x_i, output div_o);
endinterface

// File: rtl/div3_serial_checker.sv
// Serial MSB-first divisibility-by-3 detector with a Mealy div_o output.
// Optional DIV3_SERIAL_REF_CHECK_EN adds a simulation-only shadow remainder check.
module div3_serial_checker
   import div3_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   div3_serial_checker_if.slave  bus
);

   rem_e rem_q, rem_d;
   logic div_d;

   always_comb begin
      rem_d = next_rem(rem_q, bus.x_i);
      div_d = (rem_d == REM0) && !reset;
   end

   assign bus.div_o = div_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rem_q <= REM0;
      else       rem_q <= rem_d;
   end

`ifdef DIV3_SERIAL_REF_CHECK_EN
   logic [1:0] shadow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= 2'd0;
      end else begin
         assert ((bus.div_o == (((2 * int'(shadow_q) + int'(bus.x_i)) % 3) == 0)) &&
                 (rem_q != 2'b11))
         else $error("div3 ref check: shadow=%0d state=%b div_o=%b",
                     shadow_q, rem_q, bus.div_o);
         shadow_q <= 2'((2 * int'(shadow_q) + int'(bus.x_i)) % 3);
      end
   end
`endif

endmodule

// File: tb/tb_div3_serial_checker.sv
// Self-checking bench for div3_serial_checker: directed tables plus random bits
// against a running value-mod-3 reference.
module tb_div3_serial_checker;
   import div3_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   ref_rem;   // accumulated value mod 3 since last reset

   div3_serial_checker_if bus ();

   div3_serial_checker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic restart();
      @(negedge clk);
      reset    = 1'b1;
      bus.x_i  = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      ref_rem  = 0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      bus.x_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++;
         if (bus.div_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: div_o=%b expected 0", i, bus.div_o);
         end
      end
      @(negedge clk);
      bus.x_i = 1'b1;
      #1;
      checks++;
      if (bus.div_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_x1: div_o=%b expected 0", bus.div_o);
      end
      @(negedge clk);
      reset   = 1'b0;
      bus.x_i = 1'b0;
      ref_rem = 0;
      #1;
      checks++;
      if (bus.div_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: div_o=%b expected 1", bus.div_o);
      end
   endtask

   task automatic test_seq_a();
      logic sb [9]  = '{1,1,0,1,0,1,1,1,0};
      logic se [9]  = '{0,1,1,0,0,0,0,0,0};
      restart();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.x_i = sb[i];
         #1;
         checks++;
         if (bus.div_o !== se[i]) begin
            errors++;
            $display("FAIL seq_a bit %0d: div_o=%b expected %b", i, bus.div_o, se[i]);
         end
      end
   endtask

   task automatic test_seq_b();
      logic sb [6] = '{1,0,0,1,1,1};
      logic se [6] = '{0,0,0,1,0,1};
      restart();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.x_i = sb[i];
         #1;
         checks++;
         if (bus.div_o !== se[i]) begin
            errors++;
            $display("FAIL seq_b bit %0d: div_o=%b expected %b", i, bus.div_o, se[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic sb [2] = '{1,1};
      logic se [2] = '{0,1};
      // Reach REM2 (value 2), present x=1, then reset mid-cycle.
      restart();
      @(negedge clk); bus.x_i = 1'b1;
      @(negedge clk); bus.x_i = 1'b0;
      @(negedge clk); bus.x_i = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.div_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_rem2: div_o=%b expected 0", bus.div_o);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         bus.x_i = sb[i];
         #1;
         checks++;
         if (bus.div_o !== se[i]) begin
            errors++;
            $display("FAIL mid_reset_restart bit %0d: div_o=%b expected %b", i, bus.div_o, se[i]);
         end
      end
      // From REM1 with x=1 div_o is high; reset must pull it low at once.
      restart();
      @(negedge clk); bus.x_i = 1'b1;
      @(negedge clk); bus.x_i = 1'b1;
      #1;
      checks++;
      if (bus.div_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_pre: div_o=%b expected 1", bus.div_o);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.div_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async_drop: div_o=%b expected 0", bus.div_o);
      end
      @(negedge clk);
      reset   = 1'b0;
      bus.x_i = 1'b0;
      #1;
      checks++;
      if (bus.div_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_cleared: div_o=%b expected 1", bus.div_o);
      end
   endtask

   task automatic test_ones();
      logic exp;
      restart();
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         bus.x_i = 1'b1;
         #1;
         exp = (((ref_rem * 2) + 1) % 3) == 0;
         checks++;
         if (bus.div_o !== exp || exp !== ((k % 2) == 0)) begin
            errors++;
            $display("FAIL ones k=%0d: div_o=%b expected %b", k, bus.div_o, (k % 2) == 0);
         end
         ref_rem = (ref_rem * 2 + 1) % 3;
      end
   endtask

   task automatic test_random();
      logic b, exp;
      restart();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         b       = 1'($urandom_range(0, 1));
         bus.x_i = b;
         #1;
         exp = (((ref_rem * 2) + int'(b)) % 3) == 0;
         checks++;
         if (bus.div_o !== exp) begin
            errors++;
            $display("FAIL random bit %0d: x=%b div_o=%b expected %b", i, b, bus.div_o, exp);
         end
         ref_rem = (ref_rem * 2 + int'(b)) % 3;
      end
   endtask

   task automatic test_illegal();
      restart();
      @(negedge clk);
      force dut.rem_q = rem_e'(2'b11);
      bus.x_i = 1'b1;
      #1;
      checks++;
      if (bus.div_o !== 1'b1) begin
         errors++;
         $display("FAIL illegal_next: div_o=%b expected 1", bus.div_o);
      end
      // Both the illegal state and REM0 go to REM0 on x=0.
      bus.x_i = 1'b0;
      #1 release dut.rem_q;
      @(negedge clk);
      bus.x_i = 1'b1;
      #1;
      checks++;
      if (bus.div_o !== 1'b0) begin
         errors++;
         $display("FAIL illegal_recover: div_o=%b expected 0", bus.div_o);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      ref_rem = 0;
      reset   = 1'b1;
      bus.x_i = 1'b0;
      test_reset();
      test_seq_a();
      test_seq_b();
      test_mid_reset();
      test_ones();
      test_random();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div3_serial_checker.md
Name: div3_serial_checker

Overview:
- Serial divisibility-by-3 detector. Consumes a binary number one bit per clock, MSB first.
- Reports combinationally (Mealy) whether the number formed by all bits accepted since reset, plus the bit currently on x_i, is a multiple of 3.
- Used as a leaf checker on serial bitstreams; no handshake, one bit per cycle.

Parameters:
- None. The divisor is fixed at 3.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; clears the accumulated value to 0
- x_i  input  1  next serial bit (MSB first), sampled on each rising clk edge while reset is low
- div_o  output  1  1 when (accumulated value * 2 + x_i) mod 3 == 0; combinational from state and x_i

Interface decision (already decided): one clock; reset is asynchronous and active-high; ports named clk and reset.

Behaviour:
- State holds the remainder r of the accumulated value mod 3, as a 2-bit FSM with states REM0, REM1, REM2. Encoding 2'b11 is illegal.
- Next remainder: n = (2*r + x_i) mod 3. Transitions:
  - REM0: x=0 -> REM0, x=1 -> REM1
  - REM1: x=0 -> REM2, x=1 -> REM0
  - REM2: x=0 -> REM1, x=1 -> REM2
- Illegal state 2'b11 -> REM0 on the next edge.
- State register: async reset to REM0 on reset high. Otherwise r <= n on every rising clk edge; no enable, one bit consumed per cycle.
- div_o = (n == REM0) AND NOT reset. Zero latency: div_o reflects the bit currently presented on x_i, before the edge that absorbs it.
- During reset, div_o = 0 regardless of x_i.
- After reset release, every rising edge consumes x_i. Leading zeros do not change the value: 0 bits absorbed in REM0 keep REM0.
- Reset asserted mid-stream: state goes to REM0 immediately (asynchronous), and div_o drops to 0 in the same instant. On release, the stream restarts from value 0.
- Unbounded stream length; only the remainder is stored, so there is no overflow or wrap-around.
- X on x_i must not be masked. div_o may go X; state may go X.

Optional Feature:
- Macro DIV3_SERIAL_REF_CHECK_EN.
- Defined:
  - Adds a simulation-only 2-bit shadow remainder, updated as (2*shadow + x_i) % 3 using integer arithmetic.
  - Adds an immediate assertion on every rising edge, outside reset: div_o == (next shadow == 0), and the FSM state never equals 2'b11.
  - On failure, $error with the shadow and state values.
- Not defined: no extra logic and no assertions; RTL is identical otherwise.

Decomposition:
- Package div3_pkg:
  - typedef enum logic [1:0] rem_e {REM0=2'b00, REM1=2'b01, REM2=2'b10}
  - function next_rem(rem_e r, logic x) returning rem_e, which implements the transition table and maps the illegal encoding to REM0
- No sub-module. A single always_ff for the state and a single combinational block for n and div_o.

Test Plan:
- Reset held 2 cycles with x_i=0 -> div_o=0 throughout. After release with x_i=0 -> div_o=1 (value 0 is divisible).
- Bits 1,1,0,1,0,1,1,1,0 each driven after a falling edge and checked 1 ns later:
  - running values 1,3,6,13,26,53,107,215,430
  - required div_o 0,1,1,0,0,0,0,0,0
- Bits 1,0,0,1 (values 1,2,4,9) -> div_o 0,0,0,1. Then bits 1,1 (19,39) -> 0,1.
- Reset asserted mid-stream while state is REM2 with x_i=1 -> div_o drops to 0 asynchronously. After release, stream 1,1 -> div_o 0,1.
- Long run of 64 ones -> div_o alternates 0,1,0,1,... (2^k - 1 is divisible by 3 when k is even). Checked against an integer reference model.
- Force the state to 2'b11 via the bench -> next edge returns to REM0. With the macro defined, the assertion fires.
